// File: rtl/cc_pipe_comparator_pkg.sv
// Shared encodings for the pipelined comparator: compare-result codes,
// debounce FSM states and a one-hot decode helper.
package cc_pipe_comparator_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10
    } cmp_t;

    typedef enum logic {
        S_INIT   = 1'b0,
        S_STABLE = 1'b1
    } state_t;

    // Returns {gt, lt, eq}; the unused code maps to all-zero.
    function automatic logic [2:0] cmp_onehot(input cmp_t res);
        logic [2:0] v;
        case (res)
            CMP_GT:  v = 3'b100;
            CMP_LT:  v = 3'b010;
            CMP_EQ:  v = 3'b001;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cc_pipe_comparator_magnitude.sv
// Purely combinational 3-way magnitude compare, signed or unsigned
// depending on SIGNED_MODE.
module cc_magnitude_core
    import cc_pipe_comparator_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int SIGNED_MODE      = 0
) (
    input  logic [NUMBER_DATAWIDTH-1:0] i_a,
    input  logic [NUMBER_DATAWIDTH-1:0] i_b,
    output cmp_t                        o_result
);

    logic w_gt;
    logic w_lt;

    // Magnitude compare and priority encode into a single result code
    always_comb begin
        if (SIGNED_MODE != 0) begin
            w_gt = ($signed(i_a) > $signed(i_b));
            w_lt = ($signed(i_a) < $signed(i_b));
        end else begin
            w_gt = (i_a > i_b);
            w_lt = (i_a < i_b);
        end
        if (w_gt) begin
            o_result = CMP_GT;
        end else if (w_lt) begin
            o_result = CMP_LT;
        end else begin
            o_result = CMP_EQ;
        end
    end

endmodule

// File: rtl/cc_pipe_comparator.sv
// Pipelined comparator: registered raw compare, debounce of consecutive
// valid results into a stable result, and a saturating equal-sample counter.
module cc_pipe_comparator
    import cc_pipe_comparator_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int SIGNED_MODE      = 0,
    parameter int DEBOUNCE_COUNT   = 4,
    parameter int COUNTER_WIDTH    = 16
) (
    input  logic                        CC_PIPE_COMPARATOR_CLOCK_50,
    input  logic                        CC_PIPE_COMPARATOR_RESET_InHigh,
    input  logic                        CC_PIPE_COMPARATOR_valid_In,
    input  logic                        CC_PIPE_COMPARATOR_clear_In,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_PIPE_COMPARATOR_dataA_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_PIPE_COMPARATOR_dataB_InBUS,
    output logic                        CC_PIPE_COMPARATOR_greaterthan_Out,
    output logic                        CC_PIPE_COMPARATOR_lessthan_Out,
    output logic                        CC_PIPE_COMPARATOR_equal_Out,
    output logic                        CC_PIPE_COMPARATOR_resultvalid_Out,
    output logic                        CC_PIPE_COMPARATOR_change_Out,
    output logic [COUNTER_WIDTH-1:0]    CC_PIPE_COMPARATOR_eqcount_OutBUS
);

    localparam int                     RUN_W   = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [RUN_W-1:0]       RUN_MAX = RUN_W'(DEBOUNCE_COUNT);
    localparam logic [RUN_W-1:0]       RUN_ONE = RUN_W'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

    logic w_flush;
    cmp_t w_cmp;
    cmp_t w_cand_next;
    logic [RUN_W-1:0] w_run_next;
    logic w_update;

    cmp_t                     r_raw_res;
    logic                     r_raw_valid;
    cmp_t                     r_cand;
    cmp_t                     r_stable;
    logic [RUN_W-1:0]         r_run;
    state_t                   r_state;
    logic                     r_change_int;
    logic [COUNTER_WIDTH-1:0] r_eqcount;
    logic                     r_gt;
    logic                     r_lt;
    logic                     r_eq;
    logic                     r_rv;
    logic                     r_change;

    // Reset and clear share the same effect; reset simply also wins on priority.
    assign w_flush = CC_PIPE_COMPARATOR_RESET_InHigh | CC_PIPE_COMPARATOR_clear_In;

    cc_magnitude_core #(
        .NUMBER_DATAWIDTH (NUMBER_DATAWIDTH),
        .SIGNED_MODE      (SIGNED_MODE)
    ) u_core (
        .i_a      (CC_PIPE_COMPARATOR_dataA_InBUS),
        .i_b      (CC_PIPE_COMPARATOR_dataB_InBUS),
        .o_result (w_cmp)
    );

    // Debounce next-state: gaps leave the run untouched, a differing result restarts it
    always_comb begin
        w_cand_next = r_cand;
        w_run_next  = r_run;
        if (r_raw_valid) begin
            if (r_raw_res == r_cand) begin
                if (r_run != RUN_MAX) begin
                    w_run_next = r_run + RUN_ONE;
                end else begin
                    w_run_next = r_run;
                end
            end else begin
                w_cand_next = r_raw_res;
                w_run_next  = RUN_ONE;
            end
        end else begin
            w_cand_next = r_cand;
            w_run_next  = r_run;
        end
        w_update = r_raw_valid && (w_run_next == RUN_MAX) &&
                   ((r_state == S_INIT) || (w_cand_next != r_stable));
    end

    // Stage 1: capture raw compare result of the accepted operands
    always_ff @(posedge CC_PIPE_COMPARATOR_CLOCK_50) begin
        if (w_flush) begin
            r_raw_valid <= 1'b0;
            r_raw_res   <= CMP_EQ;
        end else begin
            r_raw_valid <= CC_PIPE_COMPARATOR_valid_In;
            if (CC_PIPE_COMPARATOR_valid_In) begin
                r_raw_res <= w_cmp;
            end
        end
    end

    // Stage 2 debounce FSM plus the registered output stage
    always_ff @(posedge CC_PIPE_COMPARATOR_CLOCK_50) begin
        if (w_flush) begin
            r_cand       <= CMP_EQ;
            r_run        <= '0;
            r_state      <= S_INIT;
            r_stable     <= CMP_EQ;
            r_change_int <= 1'b0;
            r_gt         <= 1'b0;
            r_lt         <= 1'b0;
            r_eq         <= 1'b0;
            r_rv         <= 1'b0;
            r_change     <= 1'b0;
        end else begin
            r_cand       <= w_cand_next;
            r_run        <= w_run_next;
            r_change_int <= w_update;
            if (w_update) begin
                r_stable <= w_cand_next;
                r_state  <= S_STABLE;
            end
            r_rv     <= (r_state == S_STABLE);
            r_change <= r_change_int;
            if (r_state == S_STABLE) begin
                {r_gt, r_lt, r_eq} <= cmp_onehot(r_stable);
            end else begin
                {r_gt, r_lt, r_eq} <= 3'b000;
            end
        end
    end

    // Saturating count of valid equal raw results
    always_ff @(posedge CC_PIPE_COMPARATOR_CLOCK_50) begin
        if (w_flush) begin
            r_eqcount <= '0;
        end else if (r_raw_valid && (r_raw_res == CMP_EQ) && (r_eqcount != CNT_MAX)) begin
            r_eqcount <= r_eqcount + CNT_ONE;
        end
    end

    assign CC_PIPE_COMPARATOR_greaterthan_Out = r_gt;
    assign CC_PIPE_COMPARATOR_lessthan_Out    = r_lt;
    assign CC_PIPE_COMPARATOR_equal_Out       = r_eq;
    assign CC_PIPE_COMPARATOR_resultvalid_Out = r_rv;
    assign CC_PIPE_COMPARATOR_change_Out      = r_change;
    assign CC_PIPE_COMPARATOR_eqcount_OutBUS  = r_eqcount;

endmodule

// File: tb/tb_cc_pipe_comparator.sv
// Directed bench: four comparator configurations share one stimulus bus;
// each scenario resets all of them and checks the relevant instance.
module tb_cc_pipe_comparator;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       clr;
    logic [7:0] a;
    logic [7:0] b;

    logic gt1, lt1, eq1, rv1, ch1;
    logic [1:0] cnt1;
    logic gts, lts, eqs, rvs, chs;
    logic [15:0] cnts;
    logic gt4, lt4, eq4, rv4, ch4;
    logic [15:0] cnt4;
    logic gt3, lt3, eq3, rv3, ch3;
    logic [15:0] cnt3;

    int checks;
    int failures;

    cc_pipe_comparator #(.NUMBER_DATAWIDTH(8), .SIGNED_MODE(0), .DEBOUNCE_COUNT(1), .COUNTER_WIDTH(2)) u1 (
        .CC_PIPE_COMPARATOR_CLOCK_50(clk), .CC_PIPE_COMPARATOR_RESET_InHigh(rst),
        .CC_PIPE_COMPARATOR_valid_In(valid), .CC_PIPE_COMPARATOR_clear_In(clr),
        .CC_PIPE_COMPARATOR_dataA_InBUS(a), .CC_PIPE_COMPARATOR_dataB_InBUS(b),
        .CC_PIPE_COMPARATOR_greaterthan_Out(gt1), .CC_PIPE_COMPARATOR_lessthan_Out(lt1),
        .CC_PIPE_COMPARATOR_equal_Out(eq1), .CC_PIPE_COMPARATOR_resultvalid_Out(rv1),
        .CC_PIPE_COMPARATOR_change_Out(ch1), .CC_PIPE_COMPARATOR_eqcount_OutBUS(cnt1));

    cc_pipe_comparator #(.NUMBER_DATAWIDTH(8), .SIGNED_MODE(1), .DEBOUNCE_COUNT(1), .COUNTER_WIDTH(16)) u1s (
        .CC_PIPE_COMPARATOR_CLOCK_50(clk), .CC_PIPE_COMPARATOR_RESET_InHigh(rst),
        .CC_PIPE_COMPARATOR_valid_In(valid), .CC_PIPE_COMPARATOR_clear_In(clr),
        .CC_PIPE_COMPARATOR_dataA_InBUS(a), .CC_PIPE_COMPARATOR_dataB_InBUS(b),
        .CC_PIPE_COMPARATOR_greaterthan_Out(gts), .CC_PIPE_COMPARATOR_lessthan_Out(lts),
        .CC_PIPE_COMPARATOR_equal_Out(eqs), .CC_PIPE_COMPARATOR_resultvalid_Out(rvs),
        .CC_PIPE_COMPARATOR_change_Out(chs), .CC_PIPE_COMPARATOR_eqcount_OutBUS(cnts));

    cc_pipe_comparator #(.NUMBER_DATAWIDTH(8), .SIGNED_MODE(0), .DEBOUNCE_COUNT(4), .COUNTER_WIDTH(16)) u4 (
        .CC_PIPE_COMPARATOR_CLOCK_50(clk), .CC_PIPE_COMPARATOR_RESET_InHigh(rst),
        .CC_PIPE_COMPARATOR_valid_In(valid), .CC_PIPE_COMPARATOR_clear_In(clr),
        .CC_PIPE_COMPARATOR_dataA_InBUS(a), .CC_PIPE_COMPARATOR_dataB_InBUS(b),
        .CC_PIPE_COMPARATOR_greaterthan_Out(gt4), .CC_PIPE_COMPARATOR_lessthan_Out(lt4),
        .CC_PIPE_COMPARATOR_equal_Out(eq4), .CC_PIPE_COMPARATOR_resultvalid_Out(rv4),
        .CC_PIPE_COMPARATOR_change_Out(ch4), .CC_PIPE_COMPARATOR_eqcount_OutBUS(cnt4));

    cc_pipe_comparator #(.NUMBER_DATAWIDTH(8), .SIGNED_MODE(0), .DEBOUNCE_COUNT(3), .COUNTER_WIDTH(16)) u3 (
        .CC_PIPE_COMPARATOR_CLOCK_50(clk), .CC_PIPE_COMPARATOR_RESET_InHigh(rst),
        .CC_PIPE_COMPARATOR_valid_In(valid), .CC_PIPE_COMPARATOR_clear_In(clr),
        .CC_PIPE_COMPARATOR_dataA_InBUS(a), .CC_PIPE_COMPARATOR_dataB_InBUS(b),
        .CC_PIPE_COMPARATOR_greaterthan_Out(gt3), .CC_PIPE_COMPARATOR_lessthan_Out(lt3),
        .CC_PIPE_COMPARATOR_equal_Out(eq3), .CC_PIPE_COMPARATOR_resultvalid_Out(rv3),
        .CC_PIPE_COMPARATOR_change_Out(ch3), .CC_PIPE_COMPARATOR_eqcount_OutBUS(cnt3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_all();
        rst = 1'b1; valid = 1'b0; clr = 1'b0; a = 8'h00; b = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_all();
        check("reset_u1_flags", {31'd0, gt1 | lt1 | eq1 | rv1 | ch1}, 32'd0);
        check("reset_u1_cnt", {30'd0, cnt1}, 32'd0);
        check("reset_u4_flags", {31'd0, gt4 | lt4 | eq4 | rv4 | ch4}, 32'd0);

        // Single GT sample with one-sample debounce; result appears two edges later
        valid = 1'b1; a = 8'h05; b = 8'h03;
        tick();
        valid = 1'b0;
        check("lat_e1_gt", {31'd0, gt1}, 32'd0);
        tick();
        check("lat_e2_gt", {31'd0, gt1}, 32'd0);
        check("lat_e2_ch", {31'd0, ch1}, 32'd0);
        tick();
        check("lat_e3_flags", {27'd0, gt1, lt1, eq1, rv1, ch1}, {27'd0, 5'b10011});
        tick();
        check("lat_e4_flags", {27'd0, gt1, lt1, eq1, rv1, ch1}, {27'd0, 5'b10010});

        // 0x80 vs 0x7F: signed says less, unsigned says greater
        reset_all();
        valid = 1'b1; a = 8'h80; b = 8'h7F;
        tick();
        valid = 1'b0;
        tick();
        tick();
        check("uns_80_7f", {27'd0, gt1, lt1, eq1, rv1, ch1}, {27'd0, 5'b10011});
        check("sgn_80_7f", {27'd0, gts, lts, eqs, rvs, chs}, {27'd0, 5'b01011});

        // Equal then greater; clear together with valid wipes everything
        reset_all();
        valid = 1'b1; a = 8'h03; b = 8'h03;
        tick();
        a = 8'h05;
        tick();
        valid = 1'b0;
        tick();
        tick();
        check("pre_clr_flags", {28'd0, gt1, lt1, eq1, rv1}, {28'd0, 4'b1001});
        check("pre_clr_cnt", {30'd0, cnt1}, 32'd1);
        clr = 1'b1; valid = 1'b1; a = 8'h03; b = 8'h03;
        tick();
        clr = 1'b0; valid = 1'b0;
        check("clr_flags", {27'd0, gt1, lt1, eq1, rv1, ch1}, 32'd0);
        check("clr_cnt", {30'd0, cnt1}, 32'd0);
        tick();
        tick();
        check("clr_discard", {27'd0, gt1, lt1, eq1, rv1, ch1}, 32'd0);
        check("clr_discard_cnt", {30'd0, cnt1}, 32'd0);

        // Same sequence, reset instead of clear
        valid = 1'b1; a = 8'h03; b = 8'h03;
        tick();
        a = 8'h05;
        tick();
        valid = 1'b0;
        tick();
        tick();
        check("pre_rst_gt", {31'd0, gt1}, 32'd1);
        rst = 1'b1; clr = 1'b1; valid = 1'b1; a = 8'h03; b = 8'h03;
        tick();
        rst = 1'b0; clr = 1'b0; valid = 1'b0;
        check("rst_flags", {27'd0, gt1, lt1, eq1, rv1, ch1}, 32'd0);
        check("rst_cnt", {30'd0, cnt1}, 32'd0);
        tick();
        tick();
        check("rst_discard", {27'd0, gt1, lt1, eq1, rv1, ch1}, 32'd0);

        // Five equal samples into a 2-bit counter saturate at 3
        reset_all();
        valid = 1'b1; a = 8'h07; b = 8'h07;
        for (int i = 0; i < 5; i++) tick();
        valid = 1'b0;
        tick();
        tick();
        check("sat_cnt", {30'd0, cnt1}, 32'd3);
        check("sat_eq", {28'd0, gt1, lt1, eq1, rv1}, {28'd0, 4'b0011});

        // Debounce of 4: 3 GT, then 5 LT; stable LT only after the 4th LT
        reset_all();
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            if (i < 3) begin a = 8'h09; b = 8'h02; end
            else begin a = 8'h02; b = 8'h09; end
            tick();
            check($sformatf("db4_init_%0d", i), {31'd0, rv4}, 32'd0);
        end
        valid = 1'b0;
        tick();
        check("db4_stable", {27'd0, gt4, lt4, eq4, rv4, ch4}, {27'd0, 5'b01011});
        tick();
        check("db4_one_pulse", {27'd0, gt4, lt4, eq4, rv4, ch4}, {27'd0, 5'b01010});
        tick();
        check("db4_no_repulse", {31'd0, ch4}, 32'd0);

        // Reset mid-run discards the partial run
        reset_all();
        valid = 1'b1; a = 8'h02; b = 8'h09;
        for (int i = 0; i < 3; i++) tick();
        valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("midrun_rst", {31'd0, rv4}, 32'd0);

        // Debounce of 3 with gaps between equal samples
        reset_all();
        a = 8'h11; b = 8'h11;
        for (int i = 0; i < 10; i++) begin
            valid = (i == 0 || i == 5 || i == 9);
            tick();
        end
        valid = 1'b0;
        check("gap_pre", {31'd0, rv3}, 32'd0);
        tick();
        check("gap_pre2", {31'd0, rv3}, 32'd0);
        tick();
        check("gap_eq", {27'd0, gt3, lt3, eq3, rv3, ch3}, {27'd0, 5'b00111});
        check("gap_cnt", {16'd0, cnt3}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cc_pipe_comparator.md
CC_PIPE_COMPARATOR -- requirements
Module: cc_pipe_comparator

Interface
REQ-001 The block SHALL have parameter NUMBER_DATAWIDTH, default 8, giving the operand width in bits (>=2).
REQ-002 The block SHALL have parameter SIGNED_MODE, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 The block SHALL have parameter DEBOUNCE_COUNT, default 4 (>=1): consecutive identical valid results required before the stable result updates.
REQ-004 The block SHALL have parameter COUNTER_WIDTH, default 16, giving the width of the equal-sample counter.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 The ports SHALL be, in this order:
- CC_PIPE_COMPARATOR_CLOCK_50  in  1  rising-edge clock
- CC_PIPE_COMPARATOR_RESET_InHigh  in  1  synchronous active-high reset
- CC_PIPE_COMPARATOR_valid_In  in  1  operands valid this cycle
- CC_PIPE_COMPARATOR_clear_In  in  1  synchronous soft clear
- CC_PIPE_COMPARATOR_dataA_InBUS  in  NUMBER_DATAWIDTH  operand A
- CC_PIPE_COMPARATOR_dataB_InBUS  in  NUMBER_DATAWIDTH  operand B
- CC_PIPE_COMPARATOR_greaterthan_Out  out  1  stable A>B
- CC_PIPE_COMPARATOR_lessthan_Out  out  1  stable A<B
- CC_PIPE_COMPARATOR_equal_Out  out  1  stable A==B
- CC_PIPE_COMPARATOR_resultvalid_Out  out  1  a stable result exists
- CC_PIPE_COMPARATOR_change_Out  out  1  one-cycle pulse on stable-result update
- CC_PIPE_COMPARATOR_eqcount_OutBUS  out  COUNTER_WIDTH  count of valid equal samples

Function
REQ-007 Stage 1 SHALL register the raw 3-way compare of A and B (per SIGNED_MODE) and a raw-valid flag when valid_In=1; raw-valid SHALL be 0 on cycles with valid_In=0.
REQ-008 Exactly one of raw gt/lt/eq SHALL be set for any registered raw result.
REQ-009 Stage 2 (debounce) SHALL hold a candidate result and a run counter sized ceil(log2(DEBOUNCE_COUNT+1)).
REQ-010 On raw-valid with raw == candidate: run counter SHALL increment, saturating at DEBOUNCE_COUNT.
REQ-011 On raw-valid with raw != candidate: candidate SHALL load raw and run counter SHALL load 1.
REQ-012 Cycles with raw-valid=0 SHALL leave candidate and run counter unchanged (gaps do not break a run).
REQ-013 FSM states SHALL be S_INIT (no stable result) and S_STABLE; S_INIT->S_STABLE when the updated run counter equals DEBOUNCE_COUNT; no return to S_INIT except reset or clear.
REQ-014 When the updated run counter equals DEBOUNCE_COUNT and (state is S_INIT or candidate != stable), stable SHALL load candidate and change_Out SHALL pulse high for exactly one cycle.
REQ-015 Latency: with DEBOUNCE_COUNT=1, a sample accepted at edge t SHALL appear on the stable outputs and change_Out after edge t+2; each extra debounce sample adds one accepted sample.
REQ-016 resultvalid_Out SHALL be 1 iff state is S_STABLE; gt/lt/eq outputs SHALL be 0 in S_INIT and one-hot in S_STABLE.
REQ-017 eqcount_OutBUS SHALL increment by 1 on each raw-valid equal result, saturating at all-ones (no wrap).
REQ-018 clear_In=1 SHALL return all state to reset values on the next edge; clear wins over a simultaneous valid_In, and that sample SHALL be discarded, including the one already in stage 1.
REQ-019 SIGNED_MODE=1 SHALL treat the MSB as sign (e.g., 8'h80 < 8'h7F).

Reset
REQ-020 On RESET_InHigh=1 at an edge: state S_INIT, candidate cleared, run counter 0, raw-valid 0, all outputs 0, eqcount 0.
REQ-021 Reset asserted mid-run SHALL discard any partial debounce run; reset SHALL take priority over clear_In and valid_In.

Structure
REQ-022 A shared package SHALL hold the 2-bit compare-result encoding (CMP_EQ, CMP_GT, CMP_LT) and the FSM state constants.
REQ-023 The combinational 3-way compare SHALL be one sub-module, cc_magnitude_core, parametrised by NUMBER_DATAWIDTH and SIGNED_MODE; all registers SHALL reside in cc_pipe_comparator.

Verification
REQ-024 DEBOUNCE_COUNT=1, unsigned: A=8'h05,B=8'h03 for one valid cycle -> gt=1, resultvalid=1, change pulse 2 cycles later.
REQ-025 DEBOUNCE_COUNT=4: 3 samples A>B, then 1 sample A<B, then 4 samples A<B -> outputs stay in S_INIT until the 4th A<B sample; then lt=1 with a single change pulse.
REQ-026 SIGNED_MODE=1 vs 0: A=8'h80,B=8'h7F (DEBOUNCE_COUNT=1) -> lt=1 signed, gt=1 unsigned.
REQ-027 Valid gaps: DEBOUNCE_COUNT=3, equal samples on cycles 0, 5, 9 -> eq=1 after the third; eqcount=3.
REQ-028 COUNTER_WIDTH=2: 5 equal samples -> eqcount saturates at 2'b11.
REQ-029 Stable gt, then clear_In together with valid_In -> all outputs 0, S_INIT, eqcount 0; same sequence with RESET_InHigh -> identical result.
